// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and load-use hazard unit for a 5-stage pipeline.
// The unit tracks in-flight writers in its own shadow EX/MEM/WB tag stages.
// From those stages it produces EX operand forwarding selects, a one-cycle
// load-use stall and ID-stage write-through bypass flags.
// Optional statistics counters: define FWD_HAZARD_STATS_EN to build them.
// With the macro undefined, stall_cnt/fwd_cnt read zero and no counter flops exist.
module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int STATS_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_dest,
  input  logic                        id_regwrite,
  input  logic                        id_is_load,
  input  logic                        flush,
  output logic                        stall,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic [NUM_SRC-1:0]          id_bypass,
  output logic [STATS_W-1:0]          stall_cnt,
  output logic [STATS_W-1:0]          fwd_cnt
);

  // Shadow EX stage
  logic                      ex_valid_q, ex_valid_d;
  logic                      ex_regwrite_q, ex_regwrite_d;
  logic                      ex_is_load_q, ex_is_load_d;
  logic [REG_AW-1:0]         ex_dest_q, ex_dest_d;
  logic [NUM_SRC*REG_AW-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]        ex_src_used_q, ex_src_used_d;

  // Shadow MEM stage
  logic                      mem_valid_q;
  logic                      mem_regwrite_q;
  logic                      mem_is_load_q;
  logic [REG_AW-1:0]         mem_dest_q;

  // Shadow WB stage. Nothing reads the WB load flag, so it is not stored.
  logic                      wb_valid_q;
  logic                      wb_regwrite_q;
  logic [REG_AW-1:0]         wb_dest_q;

  logic                      src_hit;
  logic                      ex_accept;
  logic [REG_AW-1:0]         fwd_reg;
  logic [REG_AW-1:0]         byp_reg;

  // True when a stage with these tags will write register r (r0 never counts)
  function automatic logic writer_match(input logic v, input logic rw,
                                        input logic [REG_AW-1:0] d,
                                        input logic [REG_AW-1:0] r);
    return v && rw && (d != '0) && (d == r);
  endfunction

  // Load-use detection: does any used ID operand read the load in EX?
  always_comb begin
    src_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k] && (id_src[k*REG_AW +: REG_AW] == ex_dest_q))
        src_hit = 1'b1;
    end
  end

  assign stall = id_valid && !flush && ex_valid_q && ex_is_load_q &&
                 ex_regwrite_q && (ex_dest_q != '0) && src_hit;

  assign ex_accept = id_valid && !stall && !flush;

  // Next EX contents: the ID instruction when it advances, otherwise a bubble
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_is_load_d  = 1'b0;
    ex_dest_d     = '0;
    ex_src_d      = '0;
    ex_src_used_d = '0;
    if (ex_accept) begin
      ex_valid_d    = 1'b1;
      ex_regwrite_d = id_regwrite;
      ex_is_load_d  = id_is_load;
      ex_dest_d     = id_dest;
      ex_src_d      = id_src;
      ex_src_used_d = id_src_used;
    end
  end

  // Advance the shadow tag pipeline; reset empties every stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_dest_q      <= '0;
      ex_src_q       <= '0;
      ex_src_used_q  <= '0;
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_is_load_q  <= 1'b0;
      mem_dest_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_dest_q      <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_dest_q      <= ex_dest_d;
      ex_src_q       <= ex_src_d;
      ex_src_used_q  <= ex_src_used_d;
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_is_load_q  <= ex_is_load_q;
      mem_dest_q     <= ex_dest_q;
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_dest_q      <= mem_dest_q;
    end
  end

  // EX operand selects: youngest non-load writer (MEM) first, then WB.
  // A MEM load match falls through; the stall already kept a real consumer back.
  always_comb begin
    fwd_sel = '0;
    fwd_reg = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_reg = ex_src_q[k*REG_AW +: REG_AW];
      if (ex_src_used_q[k] && (fwd_reg != '0)) begin
        if (writer_match(mem_valid_q, mem_regwrite_q, mem_dest_q, fwd_reg) &&
            !mem_is_load_q)
          fwd_sel[2*k +: 2] = 2'b10;
        else if (writer_match(wb_valid_q, wb_regwrite_q, wb_dest_q, fwd_reg))
          fwd_sel[2*k +: 2] = 2'b01;
      end
    end
  end

  // ID write-through: operand reads the register WB is writing this cycle
  always_comb begin
    id_bypass = '0;
    byp_reg   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      byp_reg      = id_src[k*REG_AW +: REG_AW];
      id_bypass[k] = id_valid && id_src_used[k] &&
                     writer_match(wb_valid_q, wb_regwrite_q, wb_dest_q, byp_reg);
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [STATS_W-1:0] stall_cnt_q;
  logic [STATS_W-1:0] fwd_cnt_q;

  // Saturating event counters for stall cycles and forwarding cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((|fwd_sel) && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: randomized and directed bench for fwd_hazard_unit.
// The reference model keeps a history of issued instructions (age 0 = EX) and
// evaluates forwarding/stall/bypass rules against it. Counters are 4 bits wide
// here so saturation is reachable; FWD_HAZARD_STATS_EN selects counter checks.
module tb_fwd_hazard_unit;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int SW = 4;
`ifdef FWD_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [NS*AW-1:0]  id_src;
  logic [NS-1:0]     id_src_used;
  logic [AW-1:0]     id_dest;
  logic              id_regwrite;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic [2*NS-1:0]   fwd_sel;
  logic [NS-1:0]     id_bypass;
  logic [SW-1:0]     stall_cnt;
  logic [SW-1:0]     fwd_cnt;

  int vectors = 0;
  int miscompares = 0;

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .STATS_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .id_bypass(id_bypass), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 v;
    logic                 rw;
    logic                 ld;
    logic [AW-1:0]        dest;
    logic [NS-1:0][AW-1:0] src;
    logic [NS-1:0]        used;
  } ins_t;

  localparam ins_t BUB = '0;

  // hist[0] = instruction in EX, hist[1] = MEM, hist[2] = WB
  ins_t     hist[$] = '{BUB, BUB, BUB};
  logic [SW-1:0] m_sc = '0;
  logic [SW-1:0] m_fc = '0;

  function automatic logic writes(input ins_t e, input logic [AW-1:0] r);
    return e.v && e.rw && (e.dest != 0) && (e.dest == r);
  endfunction

  function automatic logic [AW-1:0] id_reg(input int k);
    return id_src[k*AW +: AW];
  endfunction

  function automatic logic m_stall();
    logic dep = 1'b0;
    for (int k = 0; k < NS; k++)
      if (id_src_used[k] && writes(hist[0], id_reg(k))) dep = 1'b1;
    return id_valid && !flush && hist[0].ld && dep;
  endfunction

  function automatic logic [2*NS-1:0] m_fwd();
    logic [2*NS-1:0] f = '0;
    for (int k = 0; k < NS; k++) begin
      if (hist[0].used[k] && hist[0].src[k] != 0) begin
        if (writes(hist[1], hist[0].src[k]) && !hist[1].ld) f[2*k +: 2] = 2'b10;
        else if (writes(hist[2], hist[0].src[k]))          f[2*k +: 2] = 2'b01;
      end
    end
    return f;
  endfunction

  function automatic logic [NS-1:0] m_byp();
    logic [NS-1:0] b = '0;
    for (int k = 0; k < NS; k++)
      b[k] = id_valid && id_src_used[k] && writes(hist[2], id_reg(k));
    return b;
  endfunction

  // Advance one clock and move the model with it (no checking here)
  task automatic tick();
    logic s;
    logic [2*NS-1:0] f;
    ins_t e;
    s = m_stall();
    f = m_fwd();
    e = BUB;
    if (id_valid && !s && !flush) begin
      e.v = 1'b1; e.rw = id_regwrite; e.ld = id_is_load; e.dest = id_dest;
      e.used = id_src_used;
      for (int k = 0; k < NS; k++) e.src[k] = id_reg(k);
    end
    @(posedge clk);
    if (!rst_n) begin
      hist = '{BUB, BUB, BUB};
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (s && m_sc != '1) m_sc = m_sc + 1'b1;
      if ((|f) && m_fc != '1) m_fc = m_fc + 1'b1;
      hist.push_front(e);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic ld,
                       input logic [AW-1:0] d, input logic [AW-1:0] s0,
                       input logic [AW-1:0] s1, input logic [1:0] used,
                       input logic fl);
    id_valid = v; id_regwrite = rw; id_is_load = ld; id_dest = d;
    id_src = {s1, s0}; id_src_used = used; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 2'b11, 1'b0);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall); end
    vectors++;
    if (fwd_sel !== 4'b0000) begin miscompares++; $display("FAIL reset_fwd got %b want 0000", fwd_sel); end
    vectors++;
    if (id_bypass !== 2'b00) begin miscompares++; $display("FAIL reset_byp got %b want 00", id_bypass); end
    vectors++;
    if (stall_cnt !== '0 || fwd_cnt !== '0) begin
      miscompares++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, fwd_cnt);
    end
  endtask

  task automatic test_fwd_mem();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0); tick();  // ADD r3
    drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd3, 5'd4, 2'b11, 1'b0); tick();  // SUB r8,r3,r4
    idle();
    vectors++;
    if (fwd_sel !== 4'b0010) begin miscompares++; $display("FAIL fwd_mem got %b want 0010", fwd_sel); end
  endtask

  task automatic test_fwd_wb();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0); tick();  // ADD r5
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd1, 5'd2, 2'b11, 1'b0); tick();  // unrelated
    drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd1, 5'd5, 2'b11, 1'b0); tick(); // reads r5 on op1
    idle();
    vectors++;
    if (fwd_sel !== 4'b0100) begin miscompares++; $display("FAIL fwd_wb got %b want 0100", fwd_sel); end
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd1, 5'd5, 2'b11, 1'b0); tick();
    idle();
    vectors++;
    if (fwd_sel !== 4'b1000) begin miscompares++; $display("FAIL fwd_prio got %b want 1000", fwd_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0); tick();  // LW r7
    drive(1'b1, 1'b1, 1'b0, 5'd12, 5'd7, 5'd2, 2'b11, 1'b0);         // consumer of r7
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_one_cycle got %b want 0", stall); end
    tick();
    idle();
    vectors++;
    if (fwd_sel[1:0] !== 2'b01) begin miscompares++; $display("FAIL lu_fwd got %b want 01", fwd_sel[1:0]); end
    vectors++;
    if (stall_cnt !== (STATS ? 4'd1 : 4'd0)) begin
      miscompares++; $display("FAIL lu_cnt got %0d want %0d", stall_cnt, STATS ? 1 : 0);
    end
  endtask

  task automatic test_r0();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0); tick();  // LW r0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0);        // reads/writes r0
      vectors++;
      if (stall !== 1'b0 || fwd_sel !== 4'b0000 || id_bypass !== 2'b00) begin
        miscompares++;
        $display("FAIL r0_cycle%0d got s=%b f=%b b=%b want 0/0000/00", i, stall, fwd_sel, id_bypass);
      end
      tick();
    end
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0); tick();  // LW r7
    drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd7, 5'd0, 2'b01, 1'b1);          // flushed LW r9 reading r7
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b want 0", stall); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd13, 5'd9, 5'd0, 2'b01, 1'b0);         // would stall if r9 load entered
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_no_ex got %b want 0", stall); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0); tick();  // LW r7
    drive(1'b1, 1'b1, 1'b0, 5'd14, 5'd7, 5'd0, 2'b01, 1'b0);
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_pre_stall got %b want 1", stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0000 || id_bypass !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_stall got s=%b f=%b b=%b want 0/0000/00", stall, fwd_sel, id_bypass);
    end
  endtask

  task automatic test_bypass_and_sat();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 2'b00, 1'b0); tick();  // writer r9
    idle(); tick();
    idle(); tick();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd2, 5'd9, 2'b11, 1'b0);
    vectors++;
    if (id_bypass !== 2'b10) begin miscompares++; $display("FAIL bypass got %b want 10", id_bypass); end
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 5'd0, 2'b01, 1'b0);         // chain on r1
      tick();
    end
    vectors++;
    if (fwd_cnt !== (STATS ? 4'hF : 4'h0)) begin
      miscompares++; $display("FAIL fwd_sat got %0d want %0d", fwd_cnt, STATS ? 15 : 0);
    end
  endtask

  task automatic test_random();
    logic e_s;
    logic [2*NS-1:0] e_f;
    logic [NS-1:0] e_b;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0);
      e_s = m_stall();
      e_f = m_fwd();
      e_b = m_byp();
      vectors++;
      if (stall !== e_s) begin miscompares++; $display("FAIL rnd%0d_stall got %b want %b", i, stall, e_s); end
      vectors++;
      if (fwd_sel !== e_f) begin miscompares++; $display("FAIL rnd%0d_fwd got %b want %b", i, fwd_sel, e_f); end
      vectors++;
      if (id_bypass !== e_b) begin miscompares++; $display("FAIL rnd%0d_byp got %b want %b", i, id_bypass, e_b); end
      vectors++;
      if (stall_cnt !== (STATS ? m_sc : 4'd0) || fwd_cnt !== (STATS ? m_fc : 4'd0)) begin
        miscompares++;
        $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", i, stall_cnt, fwd_cnt,
                 STATS ? m_sc : 4'd0, STATS ? m_fc : 4'd0);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_r0();
    test_flush_and_reset();
    test_bypass_and_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
